// File: rtl/tdc_pg_burst.sv
// tdc_pg_burst: multi-channel launch-edge generator for the TDC delay lines.
// Every channel holds one launch register on clk_launch. Three modes are
// supported: registered pass-through of pg_in, a single toggle, and a burst
// of toggle edges separated by a programmable gap.
// Optional macro TDC_PG_LFSR_EN: when defined, mode 3 runs a burst whose
// per-channel toggles are gated by a 16-bit Fibonacci LFSR. When it is not
// defined, mode 3 behaves as a single toggle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting; PASS mode tracks pg_in; start is accepted here only
// ST_EDGE  | a burst edge has just become visible on the launch registers
// ST_GAP   | burst gap countdown between two edges
// ST_DONE  | done pulse cycle; start is ignored; returns to ST_IDLE
module tdc_pg_burst #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk_launch,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic [N_CH-1:0]  pg_in,
    input  logic [N_CH-1:0]  pg_bypass,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [CNT_W-1:0] gap_len,
    output logic [N_CH-1:0]  pg_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EDGE = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_BURST = 2'd2;
    localparam logic [1:0] MODE_LFSR  = 2'd3;

    state_t             state_q, state_d;
    logic [N_CH-1:0]    launch_q, launch_d;
    logic [N_CH-1:0]    mask_q, mask_d;
    logic [CNT_W-1:0]   edges_q, edges_d;
    logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   gap_len_q, gap_len_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               lfsr_mode_q, lfsr_mode_d;
    logic [15:0]        lfsr_q, lfsr_d;

    logic [N_CH-1:0]    lfsr_pat;
    logic [N_CH-1:0]    pat_start;
    logic [N_CH-1:0]    pat_run;
    logic               burst_sel;

`ifdef TDC_PG_LFSR_EN
    logic        lfsr_fb;
    logic [15:0] lfsr_step;

    // LFSR next value (x^16+x^14+x^13+x^11+1) and its per-channel toggle pattern
    always_comb begin
        lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_step = {lfsr_q[14:0], lfsr_fb};
        lfsr_pat  = '0;
        for (int i = 0; i < N_CH; i++) begin
            lfsr_pat[i] = lfsr_step[i % 16];
        end
    end

    assign burst_sel = (mode == MODE_BURST) || (mode == MODE_LFSR);
    assign pat_start = (mode == MODE_LFSR) ? (ch_mask & lfsr_pat) : ch_mask;
    assign pat_run   = lfsr_mode_q ? (mask_q & lfsr_pat) : mask_q;
`else
    // Without the LFSR option every masked channel toggles on every edge
    assign lfsr_pat  = '1;
    assign burst_sel = (mode == MODE_BURST);
    assign pat_start = ch_mask & lfsr_pat;
    assign pat_run   = mask_q & lfsr_pat;
`endif

    // Next-state logic: everything holds when en is low
    always_comb begin
        state_d     = state_q;
        launch_d    = launch_q;
        mask_d      = mask_q;
        edges_d     = edges_q;
        gap_cnt_d   = gap_cnt_q;
        gap_len_d   = gap_len_q;
        busy_d      = busy_q;
        done_d      = done_q;
        lfsr_mode_d = lfsr_mode_q;
        lfsr_d      = lfsr_q;

        if (en) begin
            done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mode == MODE_PASS) begin
                        launch_d = (launch_q & ~ch_mask) | (pg_in & ch_mask);
                    end else if (start) begin
                        mask_d    = ch_mask;
                        gap_len_d = gap_len;
                        if (burst_sel) begin
                            lfsr_mode_d = (mode == MODE_LFSR);
                            if (burst_len == '0) begin
                                done_d  = 1'b1;
                                state_d = ST_DONE;
                            end else begin
                                // First edge is issued straight from IDLE
                                launch_d  = launch_q ^ pat_start;
                                edges_d   = burst_len - CNT_W'(1);
                                gap_cnt_d = gap_len;
                                busy_d    = 1'b1;
                                state_d   = ST_EDGE;
`ifdef TDC_PG_LFSR_EN
                                if (mode == MODE_LFSR) begin
                                    lfsr_d = lfsr_step;
                                end
`endif
                            end
                        end else begin
                            // TOG, and mode 3 when the LFSR option is absent
                            launch_d = launch_q ^ ch_mask;
                            done_d   = 1'b1;
                            state_d  = ST_DONE;
                        end
                    end
                end
                ST_EDGE, ST_GAP: begin
                    if (edges_q == '0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (gap_cnt_q == '0) begin
                        launch_d  = launch_q ^ pat_run;
                        edges_d   = edges_q - CNT_W'(1);
                        gap_cnt_d = gap_len_q;
                        state_d   = ST_EDGE;
`ifdef TDC_PG_LFSR_EN
                        if (lfsr_mode_q) begin
                            lfsr_d = lfsr_step;
                        end
`endif
                    end else begin
                        gap_cnt_d = gap_cnt_q - CNT_W'(1);
                        state_d   = ST_GAP;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset; reset aborts any sequence
    always_ff @(posedge clk_launch) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            launch_q    <= '0;
            mask_q      <= '0;
            edges_q     <= '0;
            gap_cnt_q   <= '0;
            gap_len_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lfsr_mode_q <= 1'b0;
            lfsr_q      <= 16'hACE1;
        end else begin
            state_q     <= state_d;
            launch_q    <= launch_d;
            mask_q      <= mask_d;
            edges_q     <= edges_d;
            gap_cnt_q   <= gap_cnt_d;
            gap_len_q   <= gap_len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            lfsr_mode_q <= lfsr_mode_d;
            lfsr_q      <= lfsr_d;
        end
    end

    // Per-channel combinational bypass; done is suppressed while frozen
    assign pg_out = (pg_bypass & pg_in) | (~pg_bypass & launch_q);
    assign busy   = busy_q;
    assign done   = done_q & en;

endmodule

// File: tb/tb_tdc_pg_burst.sv
// Directed bench for tdc_pg_burst: reset, PASS/bypass, BURST timing,
// enable hold, reset abort, zero-length burst, toggle/mode 3, max burst.
`timescale 1ns/1ps
module tb_tdc_pg_burst;

    logic       clk_launch = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] ch_mask = 4'h0;
    logic [3:0] pg_in = 4'h0;
    logic [3:0] pg_bypass = 4'h0;
    logic [7:0] burst_len = 8'd0;
    logic [7:0] gap_len = 8'd0;
    logic [3:0] pg_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail = 0;

    tdc_pg_burst #(.N_CH(4), .CNT_W(8)) dut (
        .clk_launch (clk_launch),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .mode       (mode),
        .ch_mask    (ch_mask),
        .pg_in      (pg_in),
        .pg_bypass  (pg_bypass),
        .burst_len  (burst_len),
        .gap_len    (gap_len),
        .pg_out     (pg_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_launch = ~clk_launch;

    task automatic step;
        @(posedge clk_launch);
        #1;
    endtask

    task automatic do_reset;
        start = 1'b0;
        en = 1'b1;
        pg_bypass = 4'h0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        mode = 2'd2;
        n_checks++; if (pg_out !== 4'h0) begin n_fail++; $display("FAIL reset_pg got=%h exp=0", pg_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        step();
        n_checks++; if (pg_out !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle pg=%h busy=%b done=%b exp 0/0/0", pg_out, busy, done);
        end
    endtask

    task automatic test_pass;
        do_reset();
        mode = 2'd0; ch_mask = 4'b1011; pg_in = 4'b1111; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (pg_out !== 4'b1011) begin n_fail++; $display("FAIL pass_reg got=%b exp=1011", pg_out); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL pass_flags busy=%b done=%b exp 0/0", busy, done); end
        pg_bypass = 4'b0100;
        #1;
        n_checks++; if (pg_out !== 4'b1111) begin n_fail++; $display("FAIL pass_bypass got=%b exp=1111", pg_out); end
        pg_in = 4'b0000;
        #1;
        n_checks++; if (pg_out !== 4'b1011) begin n_fail++; $display("FAIL pass_bypass_low got=%b exp=1011", pg_out); end
        pg_bypass = 4'b0000; ch_mask = 4'b0010;
        step();
        n_checks++; if (pg_out !== 4'b1001) begin n_fail++; $display("FAIL pass_mask got=%b exp=1001", pg_out); end
    endtask

    task automatic test_burst;
        int  nedge;
        logic [3:0] exp_pg;
        do_reset();
        mode = 2'd2; burst_len = 8'd3; gap_len = 8'd2; ch_mask = 4'hF; start = 1'b1;
        nedge = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            start = 1'b0;
            if (c == 2) begin burst_len = 8'd9; gap_len = 8'd0; ch_mask = 4'h1; end
            if (c == 1 || c == 4 || c == 7) nedge++;
            exp_pg = nedge[0] ? 4'hF : 4'h0;
            n_checks++; if (pg_out !== exp_pg) begin n_fail++; $display("FAIL burst_pg c=%0d got=%h exp=%h", c, pg_out, exp_pg); end
            n_checks++; if (busy !== (c >= 1 && c <= 7)) begin n_fail++; $display("FAIL burst_busy c=%0d got=%b exp=%b", c, busy, (c >= 1 && c <= 7)); end
            n_checks++; if (done !== (c == 8)) begin n_fail++; $display("FAIL burst_done c=%0d got=%b exp=%b", c, done, (c == 8)); end
        end
    endtask

    task automatic test_en_hold;
        int  nedge;
        logic [3:0] exp_pg;
        do_reset();
        mode = 2'd2; burst_len = 8'd4; gap_len = 8'd0; ch_mask = 4'hF; start = 1'b1;
        nedge = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            en = !(c >= 2 && c <= 4);
            start = (c == 3);
            #1;
            if (c == 1 || c == 2 || c == 6 || c == 7) nedge++;
            exp_pg = nedge[0] ? 4'hF : 4'h0;
            n_checks++; if (pg_out !== exp_pg) begin n_fail++; $display("FAIL hold_pg c=%0d got=%h exp=%h", c, pg_out, exp_pg); end
            n_checks++; if (busy !== (c >= 1 && c <= 7)) begin n_fail++; $display("FAIL hold_busy c=%0d got=%b exp=%b", c, busy, (c >= 1 && c <= 7)); end
            n_checks++; if (done !== (c == 8)) begin n_fail++; $display("FAIL hold_done c=%0d got=%b exp=%b", c, done, (c == 8)); end
        end
        start = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_reset_abort;
        do_reset();
        mode = 2'd2; burst_len = 8'd5; gap_len = 8'd0; ch_mask = 4'hF; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (pg_out !== 4'hF || busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre pg=%h busy=%b exp F/1", pg_out, busy); end
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (pg_out !== 4'h0) begin n_fail++; $display("FAIL abort_pg got=%h exp=0", pg_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done c=%0d got=%b exp=0", c, done); end
            step();
        end
        burst_len = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || pg_out !== 4'h0) begin
            n_fail++; $display("FAIL zero_len done=%b busy=%b pg=%h exp 1/0/0", done, busy, pg_out);
        end
        step();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_len_after done=%b busy=%b exp 0/0", done, busy); end
    endtask

    task automatic test_toggle;
        do_reset();
        mode = 2'd1; ch_mask = 4'b0101; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (pg_out !== 4'b0101) begin n_fail++; $display("FAIL tog_pg got=%b exp=0101", pg_out); end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL tog_flags done=%b busy=%b exp 1/0", done, busy); end
        step();
        n_checks++; if (done !== 1'b0 || pg_out !== 4'b0101) begin n_fail++; $display("FAIL tog_after done=%b pg=%b exp 0/0101", done, pg_out); end
        step();
`ifdef TDC_PG_LFSR_EN
        do_reset();
        mode = 2'd3; burst_len = 8'd2; gap_len = 8'd0; ch_mask = 4'hF; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (pg_out !== 4'h3 || busy !== 1'b1) begin n_fail++; $display("FAIL lfsr_e0 pg=%h busy=%b exp 3/1", pg_out, busy); end
        step();
        n_checks++; if (pg_out !== 4'h4 || busy !== 1'b1) begin n_fail++; $display("FAIL lfsr_e1 pg=%h busy=%b exp 4/1", pg_out, busy); end
        step();
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || pg_out !== 4'h4) begin
            n_fail++; $display("FAIL lfsr_done done=%b busy=%b pg=%h exp 1/0/4", done, busy, pg_out);
        end
`else
        mode = 2'd3; ch_mask = 4'hF; burst_len = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (pg_out !== 4'b1010) begin n_fail++; $display("FAIL mode3_pg got=%b exp=1010", pg_out); end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mode3_flags done=%b busy=%b exp 1/0", done, busy); end
        step();
        n_checks++; if (done !== 1'b0 || pg_out !== 4'b1010) begin n_fail++; $display("FAIL mode3_after done=%b pg=%b exp 0/1010", done, pg_out); end
`endif
    endtask

    task automatic test_max_burst;
        int done_c;
        int nbusy;
        do_reset();
        mode = 2'd2; burst_len = 8'd255; gap_len = 8'd0; ch_mask = 4'b0001; start = 1'b1;
        done_c = 0;
        nbusy = 0;
        for (int c = 1; c <= 300; c++) begin
            step();
            start = 1'b0;
            if (done) begin done_c = c; break; end
            if (busy) nbusy++;
        end
        n_checks++; if (done_c != 256) begin n_fail++; $display("FAIL max_done_cycle got=%0d exp=256", done_c); end
        n_checks++; if (nbusy != 255) begin n_fail++; $display("FAIL max_busy_cycles got=%0d exp=255", nbusy); end
        n_checks++; if (pg_out !== 4'b0001 || busy !== 1'b0) begin n_fail++; $display("FAIL max_final pg=%b busy=%b exp 0001/0", pg_out, busy); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_burst();
        test_en_hold();
        test_reset_abort();
        test_toggle();
        test_max_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
